wash_cycle_ctrl: RTL and testbench
==================================

WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 Parameter CYC_PER_SEC, default 8: Clk cycles per timer second; 8,000,000 in the product build, 8 for simulation.
REQ-002 Parameter FILL_SEC, default 2: FILLING duration in seconds.
REQ-003 Parameter WASH_SEC, default 5: WASHING duration in seconds.
REQ-004 Parameter RINSE_SEC, default 2: RINSING duration in seconds.
REQ-005 Parameter SPIN_SEC, default 1: SPINNING duration in seconds.
REQ-006 The block SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-007 Clk  in  1  system clock, rising-edge.
REQ-008 RST  in  1  asynchronous active-high reset.
REQ-009 Coin_In  in  1  start request, level-sampled; honoured in IDLE only.
REQ-010 Double_Wash  in  1  extra wash+rinse pass; sampled on the start cycle only.
REQ-011 Lid_Open  in  1  pause; freezes all timing while high.
REQ-012 Cancel  in  1  abort to IDLE.
REQ-013 State  out  3  0=IDLE, 1=FILLING, 2=WASHING, 3=RINSING, 4=SPINNING.
REQ-014 Busy  out  1  high in any state other than IDLE.
REQ-015 Water_Valve  out  1  high in FILLING only.
REQ-016 Motor_En  out  1  high in WASHING, RINSING or SPINNING, and low whenever Lid_Open is high.
REQ-017 Wash_Done  out  1  one-cycle pulse when a cycle completes normally.

Function
REQ-018 Timing SHALL use a prescaler counting 0..CYC_PER_SEC-1 and a seconds counter sized for the largest *_SEC value.
REQ-019 Both counters SHALL clear on every state entry, so each state lasts exactly DUR*CYC_PER_SEC unpaused cycles.
REQ-020 A state SHALL end on the cycle where the prescaler = CYC_PER_SEC-1, the seconds counter = DUR-1 and Lid_Open = 0.
REQ-021 The state change SHALL be visible after the next rising edge.
REQ-022 IDLE with Coin_In=1 and Cancel=0: next state FILLING; Double_Wash latched into an internal pass flag.
REQ-023 Sequence: FILLING -> WASHING -> RINSING; RINSING -> WASHING if the pass flag is set (flag then clears), else RINSING -> SPINNING; SPINNING -> IDLE.
REQ-024 Wash_Done SHALL be high for exactly one cycle, the first IDLE cycle after SPINNING expires.
REQ-025 Lid_Open=1 SHALL hold both counters and the state unchanged; timing resumes from the held count when the lid closes.
REQ-026 Cancel=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the counters and the pass flag, and produce no Wash_Done.
REQ-027 Cancel has priority over expiry and over Lid_Open.
REQ-028 Cancel and Coin_In both high in IDLE: remain IDLE.
REQ-029 Coin_In while Busy SHALL be ignored; Double_Wash changes after start SHALL be ignored.
REQ-030 Coin_In held high through SPINNING -> IDLE: FILLING starts on the cycle after the Wash_Done cycle.
REQ-031 Outputs SHALL be decoded from registered state.
REQ-032 Motor_En is the only output with a combinational input path, gated by Lid_Open.
REQ-033 Undefined State encodings 5-7 SHALL return to IDLE on the next edge.

Reset
REQ-034 RST=1 SHALL immediately force, without waiting for Clk: State=0, Busy=0, Water_Valve=0, Motor_En=0, Wash_Done=0, counters=0, pass flag=0.
REQ-035 Reset asserted mid-cycle SHALL abort with no Wash_Done.
REQ-036 After RST deasserts, the first rising edge SHALL evaluate normally from IDLE.

Verification (default parameters)
REQ-037 Single cycle: Coin_In pulse, Double_Wash=0 -> FILLING 16 cycles, WASHING 40, RINSING 16, SPINNING 8; Wash_Done pulses once, 80 cycles after the start edge.
REQ-038 Double wash: Coin_In with Double_Wash=1 -> F, W, R, W, R, S; Wash_Done 136 cycles after start; Double_Wash toggling mid-run has no effect.
REQ-039 Lid pause: Lid_Open high for 20 cycles at WASHING cycle 10 -> Motor_En=0 during the pause; WASHING lasts 60 cycles total; Wash_Done at 100.
REQ-040 Cancel: Cancel pulse in RINSING -> IDLE next edge, Busy=0, no Wash_Done; Cancel coincident with expiry also goes to IDLE.
REQ-041 Async reset: RST asserted mid-SPINNING between clock edges -> outputs zero immediately; a Coin_In after release restarts at FILLING with a full 16-cycle fill.
REQ-042 Held coin / ignored coin: Coin_In held high for a whole run -> back-to-back cycles with one Wash_Done per cycle; Coin_In pulsed during WASHING -> no effect.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: FILLING -> WASHING -> RINSING [-> WASHING -> RINSING] -> SPINNING.
// Each phase is timed by a prescaler plus a seconds counter; the lid freezes timing and Cancel aborts.
module wash_cycle_ctrl #(
  parameter int CYC_PER_SEC = 8,
  parameter int FILL_SEC    = 2,
  parameter int WASH_SEC    = 5,
  parameter int RINSE_SEC   = 2,
  parameter int SPIN_SEC    = 1
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       Coin_In,
  input  logic       Double_Wash,
  input  logic       Lid_Open,
  input  logic       Cancel,
  output logic [2:0] State,
  output logic       Busy,
  output logic       Water_Valve,
  output logic       Motor_En,
  output logic       Wash_Done
);

  localparam int MAX_FW  = (FILL_SEC > WASH_SEC) ? FILL_SEC : WASH_SEC;
  localparam int MAX_RS  = (RINSE_SEC > SPIN_SEC) ? RINSE_SEC : SPIN_SEC;
  localparam int MAX_SEC = (MAX_FW > MAX_RS) ? MAX_FW : MAX_RS;
  localparam int SEC_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC + 1) : 1;
  localparam int PRE_W   = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CYC_PER_SEC - 1);
  localparam logic [SEC_W-1:0] FILL_LAST  = SEC_W'(FILL_SEC - 1);
  localparam logic [SEC_W-1:0] WASH_LAST  = SEC_W'(WASH_SEC - 1);
  localparam logic [SEC_W-1:0] RINSE_LAST = SEC_W'(RINSE_SEC - 1);
  localparam logic [SEC_W-1:0] SPIN_LAST  = SEC_W'(SPIN_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic [SEC_W-1:0] sec_last;
  logic             at_end;

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    sec_d    = sec_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    sec_last = '0;

    case (state_q)
      S_FILL:  sec_last = FILL_LAST;
      S_WASH:  sec_last = WASH_LAST;
      S_RINSE: sec_last = RINSE_LAST;
      S_SPIN:  sec_last = SPIN_LAST;
      default: sec_last = '0;
    endcase

    at_end = (pre_q == PRE_LAST) && (sec_q == sec_last) && !Lid_Open;

    if (!Lid_Open) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        sec_d = sec_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        sec_d = '0;
        if (Coin_In && !Cancel) begin
          state_d = S_FILL;
          pass_d  = Double_Wash;
        end
      end
      S_FILL:  if (at_end) state_d = S_WASH;
      S_WASH:  if (at_end) state_d = S_RINSE;
      S_RINSE: begin
        if (at_end) begin
          if (pass_q) begin
            state_d = S_WASH;
            pass_d  = 1'b0;
          end else begin
            state_d = S_SPIN;
          end
        end
      end
      S_SPIN: begin
        if (at_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pass_d  = 1'b0;
      end
    endcase

    // Cancel wins over expiry and over the lid pause
    if (Cancel && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      done_d  = 1'b0;
    end

    if (state_d != state_q) begin
      pre_d = '0;
      sec_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      sec_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign State       = state_q;
  assign Busy        = (state_q != S_IDLE);
  assign Water_Valve = (state_q == S_FILL);
  assign Motor_En    = ((state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN))
                       && !Lid_Open;
  assign Wash_Done   = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl: a phase-by-phase vector table plus hand-written
// sequences for double wash, cancel, async reset and coin handling.
module tb_wash_cycle_ctrl;

  logic       Clk = 1'b0;
  logic       RST;
  logic       Coin_In, Double_Wash, Lid_Open, Cancel;
  logic [2:0] State;
  logic       Busy, Water_Valve, Motor_En, Wash_Done;

  int n_checks = 0;
  int n_fail   = 0;

  wash_cycle_ctrl dut (
    .Clk         (Clk),
    .RST         (RST),
    .Coin_In     (Coin_In),
    .Double_Wash (Double_Wash),
    .Lid_Open    (Lid_Open),
    .Cancel      (Cancel),
    .State       (State),
    .Busy        (Busy),
    .Water_Valve (Water_Valve),
    .Motor_En    (Motor_En),
    .Wash_Done   (Wash_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       coin, dbl, lid, cancel;
    int         n;
    logic [2:0] st;
    logic       busy, valve, motor, done;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] SEQ_SGL = {17'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  localparam logic [31:0] SEQ_DBL = {11'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic busy,
                            input logic valve, input logic motor, input logic done);
    check({tag, ".state"}, 32'(State), 32'(st));
    check({tag, ".busy"},  32'(Busy), 32'(busy));
    check({tag, ".valve"}, 32'(Water_Valve), 32'(valve));
    check({tag, ".motor"}, 32'(Motor_En), 32'(motor));
    check({tag, ".done"},  32'(Wash_Done), 32'(done));
  endtask

  // Starts a run and counts edges after the start edge until Wash_Done is seen.
  task automatic run_cycle(input logic dbl, input bit toggle, input int coin_at,
                           output int cnt, output logic [31:0] seq);
    logic [2:0] prev;
    Coin_In     = 1'b1;
    Double_Wash = dbl;
    tick();
    Coin_In = 1'b0;
    cnt  = 0;
    seq  = 32'(State);
    prev = State;
    while (Wash_Done !== 1'b1 && cnt < 400) begin
      Coin_In = (cnt == coin_at);
      if (toggle) Double_Wash = ~Double_Wash;
      tick();
      cnt++;
      if (State !== prev) begin
        seq  = (seq << 3) | 32'(State);
        prev = State;
      end
    end
    Coin_In     = 1'b0;
    Double_Wash = 1'b0;
  endtask

  initial begin
    int          cnt;
    logic [31:0] seq;
    bit          saw_done;

    RST = 1'b1; Coin_In = 1'b0; Double_Wash = 1'b0; Lid_Open = 1'b0; Cancel = 1'b0;
    #1;
    check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #21;
    RST = 1'b0;
    tick();
    check_outs("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // coin, dbl, lid, cancel, n, state, busy, valve, motor, done
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 15, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 39, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 15, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  7, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    // lid pause inside WASHING, including a hold exactly on the expiry count
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0,  1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 20, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 29, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  8, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      Coin_In     = tbl[i].coin;
      Double_Wash = tbl[i].dbl;
      Lid_Open    = tbl[i].lid;
      Cancel      = tbl[i].cancel;
      repeat (tbl[i].n) tick();
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].busy, tbl[i].valve,
                 tbl[i].motor, tbl[i].done);
    end
    Coin_In = 1'b0; Lid_Open = 1'b0; Cancel = 1'b0; Double_Wash = 1'b0;

    // single run with Double_Wash toggling after start
    run_cycle(1'b0, 1'b1, -1, cnt, seq);
    check("single.latency", 32'(cnt), 32'd80);
    check("single.seq", seq, SEQ_SGL);
    tick();
    check("single.done_one_cycle", 32'(Wash_Done), 32'd0);

    // double wash with Double_Wash toggling after start
    run_cycle(1'b1, 1'b1, -1, cnt, seq);
    check("double.latency", 32'(cnt), 32'd136);
    check("double.seq", seq, SEQ_DBL);
    tick();

    // coin pulsed mid-WASHING is ignored
    run_cycle(1'b0, 1'b0, 30, cnt, seq);
    check("ignored_coin.latency", 32'(cnt), 32'd80);
    check("ignored_coin.seq", seq, SEQ_SGL);
    tick();

    // cancel in RINSING
    Coin_In = 1'b1; tick(); Coin_In = 1'b0;
    repeat (60) tick();
    check("cancel_pre.state", 32'(State), 32'd3);
    Cancel = 1'b1; tick(); Cancel = 1'b0;
    check("cancel.state", 32'(State), 32'd0);
    check("cancel.busy", 32'(Busy), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (Wash_Done === 1'b1 || State !== 3'd0) saw_done = 1'b1;
      tick();
    end
    check("cancel.no_done_stays_idle", 32'(saw_done), 32'd0);

    // cancel on the FILLING expiry cycle
    Coin_In = 1'b1; tick(); Coin_In = 1'b0;
    repeat (15) tick();
    Cancel = 1'b1; tick(); Cancel = 1'b0;
    check("cancel_fill_expiry.state", 32'(State), 32'd0);

    // cancel on the SPINNING expiry cycle must not pulse Wash_Done
    Coin_In = 1'b1; tick(); Coin_In = 1'b0;
    repeat (79) tick();
    check("cancel_spin_pre.state", 32'(State), 32'd4);
    Cancel = 1'b1; tick(); Cancel = 1'b0;
    check("cancel_spin.state", 32'(State), 32'd0);
    check("cancel_spin.done", 32'(Wash_Done), 32'd0);
    tick();
    check("cancel_spin.done_after", 32'(Wash_Done), 32'd0);

    // cancel beats lid pause
    Coin_In = 1'b1; tick(); Coin_In = 1'b0;
    repeat (20) tick();
    Lid_Open = 1'b1; Cancel = 1'b1; tick(); Lid_Open = 1'b0; Cancel = 1'b0;
    check("cancel_lid.state", 32'(State), 32'd0);

    // cancel and coin together in IDLE
    Coin_In = 1'b1; Cancel = 1'b1; tick(); Coin_In = 1'b0; Cancel = 1'b0;
    check("cancel_coin_idle.state", 32'(State), 32'd0);

    // async reset mid-SPINNING, between edges
    Coin_In = 1'b1; tick(); Coin_In = 1'b0;
    repeat (75) tick();
    check("reset_pre.state", 32'(State), 32'd4);
    #2 RST = 1'b1;
    #1;
    check_outs("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    repeat (10) tick();
    check("reset.no_done", 32'(Wash_Done), 32'd0);
    Coin_In = 1'b1; tick(); Coin_In = 1'b0;
    check("reset_restart.state", 32'(State), 32'd1);
    repeat (15) tick();
    check("reset_restart.fill15", 32'(State), 32'd1);
    tick();
    check("reset_restart.fill16", 32'(State), 32'd2);
    Cancel = 1'b1; tick(); Cancel = 1'b0;

    // coin held high: back-to-back runs, one Wash_Done per run
    Coin_In = 1'b1;
    tick();
    cnt = 0;
    while (Wash_Done !== 1'b1 && cnt < 400) begin tick(); cnt++; end
    check("held.first_latency", 32'(cnt), 32'd80);
    tick();
    check("held.restart_state", 32'(State), 32'd1);
    check("held.done_cleared", 32'(Wash_Done), 32'd0);
    cnt = 1;
    while (Wash_Done !== 1'b1 && cnt < 400) begin tick(); cnt++; end
    check("held.second_period", 32'(cnt), 32'd81);
    Coin_In = 1'b0;
    tick();
    check("held.final_state", 32'(State), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
